// File: rtl/pck_isa.sv
// Shared ISA definitions for the execute stage.
//   isa_instr_e    : decoded instruction class driven by the decoder
//   muldiv_state_e : state encoding of the multiply/divide sequencer
//   is_muldiv()    : 1 for the RV32 M extension ops (isa_mul..isa_remu)
//   is_mul_op()    : 1 for the multiply half of the M range
//   is_div_op()    : 1 for the divide/remainder half of the M range
package pck_isa;

  typedef enum logic [5:0] {
    isa_nop,
    isa_add,
    isa_sub,
    isa_and,
    isa_or,
    isa_xor,
    isa_sll,
    isa_srl,
    isa_sra,
    isa_slt,
    isa_sltu,
    isa_mul,
    isa_mulh,
    isa_mulsu,
    isa_mulu,
    isa_div,
    isa_divu,
    isa_rem,
    isa_remu,
    isa_lw,
    isa_sw
  } isa_instr_e;

  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIXUP, MD_DONE} muldiv_state_e;

  function automatic logic is_muldiv(isa_instr_e op);
    return (op >= isa_mul) && (op <= isa_remu);
  endfunction

  function automatic logic is_mul_op(isa_instr_e op);
    return (op >= isa_mul) && (op <= isa_mulu);
  endfunction

  function automatic logic is_div_op(isa_instr_e op);
    return (op >= isa_div) && (op <= isa_remu);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign helpers for the multiply/divide sequencer.
//   rs1_i/rs2_i            : raw operands
//   rs1_signed_i/rs2_signed_i : treat operand as two's complement
//   rs1_neg_o/rs2_neg_o    : operand is negative under that signedness
//   rs1_abs_o/rs2_abs_o    : operand magnitude (0x80000000 stays 0x80000000,
//                            which is the correct unsigned magnitude 2^31)
//   acc_i                  : unsigned iteration result (product, or {rem, quo})
//   prod_neg_i/quo_neg_i/rem_neg_i : negate the respective result
//   prod_o/quo_o/rem_o     : signed-corrected product / quotient / remainder
module muldiv_sign_fix (
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic        rs1_signed_i,
  input  logic        rs2_signed_i,
  output logic        rs1_neg_o,
  output logic        rs2_neg_o,
  output logic [31:0] rs1_abs_o,
  output logic [31:0] rs2_abs_o,
  input  logic [63:0] acc_i,
  input  logic        prod_neg_i,
  input  logic        quo_neg_i,
  input  logic        rem_neg_i,
  output logic [63:0] prod_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  assign rs1_neg_o = rs1_signed_i & rs1_i[31];
  assign rs2_neg_o = rs2_signed_i & rs2_i[31];
  assign rs1_abs_o = rs1_neg_o ? (~rs1_i + 32'd1) : rs1_i;
  assign rs2_abs_o = rs2_neg_o ? (~rs2_i + 32'd1) : rs2_i;

  assign prod_o = prod_neg_i ? (~acc_i + 64'd1) : acc_i;
  assign quo_o  = quo_neg_i  ? (~acc_i[31:0] + 32'd1)  : acc_i[31:0];
  assign rem_o  = rem_neg_i  ? (~acc_i[63:32] + 32'd1) : acc_i[63:32];

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32 M-extension sequencer: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, sitting beside the ALU.
//   clk, reset_n            : clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o : request handshake; ready only in IDLE and not killed
//   req_op_i, rs1_i, rs2_i  : decoded M op and its operands
//   kill_i                  : flush; returns to IDLE and suppresses rsp_valid_o
//   rsp_valid_o/rsp_ready_i : response handshake
//   rsp_data_o              : registered result, stable while rsp_valid_o is high
//   busy_o                  : state != IDLE (core stall)
//   state_o                 : current FSM state, for debug and checkers
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and once the response is valid it
// and its data stay unchanged until the transfer (or a kill/reset).
module muldiv_seq
  import pck_isa::*;
#(
  parameter int XLEN      = 32,
  parameter bit FAST_DIV0 = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  isa_instr_e      req_op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            busy_o,
  output muldiv_state_e   state_o
);

  localparam logic [4:0] CNT_LOAD = 5'(XLEN - 1);

  muldiv_state_e   state_q, state_d;
  isa_instr_e      op_q, op_d;
  logic [XLEN-1:0] b_q, b_d;            // multiplicand (mul) or divisor (div)
  logic [63:0]     acc_q, acc_d;        // {hi, multiplier} or {remainder, dividend/quotient}
  logic [4:0]      cnt_q, cnt_d;
  logic            neg_q, neg_d;        // product / quotient sign
  logic            s1neg_q, s1neg_d;    // remainder sign
  logic            force_q, force_d;    // divide-by-zero or signed overflow
  logic [XLEN-1:0] force_val_q, force_val_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;

  logic        rs1_signed, rs2_signed, rs1_neg, rs2_neg;
  logic [31:0] rs1_abs, rs2_abs, quo_fix, rem_fix;
  logic [63:0] prod_fix;
  logic        accept, div_zero, div_ovf, special;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, div_next;
  logic [32:0] div_top;
  logic [31:0] div_rem;
  logic        div_borrow;
  logic [31:0] result_sel;

  assign rs1_signed = (req_op_i == isa_mul) || (req_op_i == isa_mulh) || (req_op_i == isa_mulsu) ||
                      (req_op_i == isa_div) || (req_op_i == isa_rem);
  assign rs2_signed = (req_op_i == isa_mul) || (req_op_i == isa_mulh) ||
                      (req_op_i == isa_div) || (req_op_i == isa_rem);

  muldiv_sign_fix u_sign_fix (
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .rs1_signed_i (rs1_signed),
    .rs2_signed_i (rs2_signed),
    .rs1_neg_o    (rs1_neg),
    .rs2_neg_o    (rs2_neg),
    .rs1_abs_o    (rs1_abs),
    .rs2_abs_o    (rs2_abs),
    .acc_i        (acc_q),
    .prod_neg_i   (neg_q),
    .quo_neg_i    (neg_q),
    .rem_neg_i    (s1neg_q),
    .prod_o       (prod_fix),
    .quo_o        (quo_fix),
    .rem_o        (rem_fix)
  );

  assign req_ready_o = (state_q == MD_IDLE) && !kill_i;
  assign rsp_valid_o = (state_q == MD_DONE) && !kill_i;
  assign busy_o      = (state_q != MD_IDLE);
  assign rsp_data_o  = rsp_data_q;
  assign state_o     = state_q;
  assign accept      = req_valid_i && req_ready_o;

  // RISC-V defines fixed results for these; they are forced in FIXUP.
  assign div_zero = is_div_op(req_op_i) && (rs2_i == '0);
  assign div_ovf  = ((req_op_i == isa_div) || (req_op_i == isa_rem)) &&
                    (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
  assign special  = div_zero || div_ovf;

  // Multiply step: add multiplicand into the high half when the multiplier
  // LSB is set, then shift the whole {carry, hi, multiplier} right by one.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Restoring divide step: the next dividend bit is shifted into the
  // remainder; the trial remainder can be 33 bits, so compare at that width.
  // On success the difference is below the divisor and fits in 32 bits.
  assign div_top    = acc_q[63:31];
  assign div_borrow = div_top < {1'b0, b_q};
  assign div_rem    = div_top[31:0] - b_q;
  assign div_next   = div_borrow ? {acc_q[62:0], 1'b0} : {div_rem, acc_q[30:0], 1'b1};

  always_comb begin
    result_sel = quo_fix;
    case (op_q)
      isa_mul:                     result_sel = prod_fix[31:0];
      isa_mulh, isa_mulsu, isa_mulu: result_sel = prod_fix[63:32];
      isa_rem, isa_remu:           result_sel = rem_fix;
      default:                     result_sel = quo_fix;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    s1neg_d     = s1neg_q;
    force_d     = force_q;
    force_val_d = force_val_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          op_d        = req_op_i;
          b_d         = is_mul_op(req_op_i) ? rs1_abs : rs2_abs;
          acc_d       = {32'd0, (is_mul_op(req_op_i) ? rs2_abs : rs1_abs)};
          neg_d       = rs1_neg ^ rs2_neg;
          s1neg_d     = rs1_neg;
          cnt_d       = CNT_LOAD;
          force_d     = special;
          if (div_zero) begin
            force_val_d = ((req_op_i == isa_div) || (req_op_i == isa_divu)) ? 32'hFFFF_FFFF : rs1_i;
          end else begin
            force_val_d = (req_op_i == isa_div) ? 32'h8000_0000 : 32'd0;
          end
          if (!is_muldiv(req_op_i)) begin
            state_d    = MD_DONE;
            rsp_data_d = '0;
          end else if (FAST_DIV0 && special) begin
            state_d = MD_FIXUP;
          end else begin
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        acc_d = is_mul_op(op_q) ? mul_next : div_next;
        if (cnt_q == 5'd0) begin
          state_d = MD_FIXUP;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      MD_FIXUP: begin
        rsp_data_d = force_q ? force_val_q : result_sel;
        state_d    = MD_DONE;
      end
      MD_DONE: begin
        if (rsp_ready_i) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (kill_i) state_d = MD_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= MD_IDLE;
      op_q        <= isa_nop;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      s1neg_q     <= 1'b0;
      force_q     <= 1'b0;
      force_val_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      s1neg_q     <= s1neg_d;
      force_q     <= force_d;
      force_val_q <= force_val_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Illegal ops are answered with 0, but they indicate a decoder bug.
  a_legal_op : assert property (@(posedge clk) disable iff (!reset_n)
    accept |-> is_muldiv(req_op_i));

endmodule
